// File: rtl/msx_pkg.sv
// Shared definitions for the VDP CPU interface.
//   - I/O port numbers of the VDP data (0x98) and control/status (0x99) ports
//   - VRAM request FSM state encoding
//   - Bit positions inside the status register and R1
//   - Captured CPU access record used for held (wait-stated) accesses
package msx_pkg;

    localparam logic [7:0] PORT_DATA = 8'h98;
    localparam logic [7:0] PORT_CTRL = 8'h99;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_REQ = 2'd1,
        ST_RD_REQ = 2'd2
    } vdp_state_t;

    // Status register layout: {F, 5S, C, fifth sprite number[4:0]}
    localparam int STAT_F  = 7;
    localparam int STAT_5S = 6;
    localparam int STAT_C  = 5;

    // R1 interrupt-enable bit
    localparam int R1_IE = 5;

    // One CPU bus access as decoded at its start
    typedef struct packed {
        logic       wr;    // 1 = write, 0 = read
        logic       ctrl;  // 1 = port 0x99, 0 = port 0x98
        logic [7:0] data;  // write data (don't care for reads)
    } cpu_acc_t;

endpackage

// File: rtl/vdp_status.sv
// VDP status register and interrupt output.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   frame_stb             : sets F (end of active frame)
//   coll_stb              : sets C (sprite collision)
//   fifth_stb, fifth_num  : sets 5S and captures the sprite number while 5S=0
//   rd_clr                : status read in progress; clears F, 5S, C
//   irq_en                : R1 interrupt enable
//   status                : {F, 5S, C, num[4:0]}
//   int_n                 : registered !(F & irq_en)
module vdp_status
    import msx_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_stb,
    input  logic       coll_stb,
    input  logic       fifth_stb,
    input  logic [4:0] fifth_num,
    input  logic       rd_clr,
    input  logic       irq_en,
    output logic [7:0] status,
    output logic       int_n
);

    logic       r_f;
    logic       r_5s;
    logic       r_c;
    logic [4:0] r_num;
    logic       r_int_n;

    // A set arriving in the same cycle as the read-clear wins, so the event
    // is not lost between the CPU sampling status and the clear taking hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_f     <= 1'b0;
            r_5s    <= 1'b0;
            r_c     <= 1'b0;
            r_num   <= 5'd0;
            r_int_n <= 1'b1;
        end else begin
            r_f <= frame_stb | (r_f & ~rd_clr);
            r_c <= coll_stb  | (r_c & ~rd_clr);
            // Only the first fifth-sprite event since the last read is kept.
            if (fifth_stb && !r_5s) begin
                r_5s  <= 1'b1;
                r_num <= fifth_num;
            end else if (rd_clr) begin
                r_5s  <= 1'b0;
            end
            r_int_n <= ~(r_f & irq_en);
        end
    end

    always_comb begin
        status          = 8'h00;
        status[STAT_F]  = r_f;
        status[STAT_5S] = r_5s;
        status[STAT_C]  = r_c;
        status[4:0]     = r_num;
    end

    assign int_n = r_int_n;

endmodule

// File: rtl/vdp_cpu_if.sv
// CPU-side I/O interface of the VDP.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   clk_en                  : CPU clock enable; bus strobes are sampled only here
//   io_addr, io_rd_n,
//   io_wr_n, din            : CPU I/O bus (ports 0x98 data, 0x99 control/status)
//   dout                    : read data captured at the start of a read access
//   wait_n                  : low while an access is held behind a busy VRAM request
//   int_n                   : VDP interrupt, active-low
//   vram_req/we/addr/wdata  : VRAM request to the video block, held until ack
//   vram_ack, vram_rdata    : one-cycle completion and read data
//   regs                    : R7..R0 packed {R7,...,R0}
//   frame_stb, coll_stb,
//   fifth_stb, fifth_num    : status events from the video block
module vdp_cpu_if
    import msx_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic [7:0]  io_addr,
    input  logic        io_rd_n,
    input  logic        io_wr_n,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        wait_n,
    output logic        int_n,
    output logic        vram_req,
    output logic        vram_we,
    output logic [13:0] vram_addr,
    output logic [7:0]  vram_wdata,
    input  logic        vram_ack,
    input  logic [7:0]  vram_rdata,
    output logic [63:0] regs,
    input  logic        frame_stb,
    input  logic        coll_stb,
    input  logic        fifth_stb,
    input  logic [4:0]  fifth_num
);

    vdp_state_t      r_state;
    vdp_state_t      w_state_nxt;

    logic            r_rd_q;
    logic            r_wr_q;
    logic [7:0]      r_latch;
    logic            r_toggle;
    logic [13:0]     r_addr;
    logic [7:0]      r_buf;
    logic [7:0]      r_dout;
    logic [7:0]      r_wdata;
    logic [7:0][7:0] r_regs;
    logic            r_pend_vld;
    cpu_acc_t        r_pend;

    logic            w_rd_start;
    logic            w_wr_start;
    logic            w_is_data;
    logic            w_is_ctrl;
    logic            w_fresh;
    logic            w_fresh_fsm;
    cpu_acc_t        w_fresh_acc;
    logic            w_busy;
    logic            w_hold;
    logic            w_release;
    logic            w_act;
    cpu_acc_t        w_acc;
    logic            w_do_latch;
    logic            w_do_ctrl2;
    logic            w_do_reg;
    logic            w_do_addr;
    logic            w_do_vwr;
    logic            w_do_drd;
    logic            w_do_srd;
    logic            w_issue_wr;
    logic            w_issue_rd;
    logic            w_ack;
    logic [7:0]      w_status;

    // ---------------------------------------------------------------
    // Access detection: a strobe counts when sampled low on a clk_en
    // cycle after having been sampled high on the previous clk_en cycle.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_q <= 1'b1;
            r_wr_q <= 1'b1;
        end else if (clk_en) begin
            r_rd_q <= io_rd_n;
            r_wr_q <= io_wr_n;
        end
    end

    assign w_rd_start = clk_en & ~io_rd_n & r_rd_q;
    assign w_wr_start = clk_en & ~io_wr_n & r_wr_q;
    assign w_is_data  = (io_addr == PORT_DATA);
    assign w_is_ctrl  = (io_addr == PORT_CTRL);
    assign w_fresh    = (w_rd_start | w_wr_start) & (w_is_data | w_is_ctrl);

    always_comb begin
        w_fresh_acc      = '0;
        w_fresh_acc.wr   = w_wr_start;
        w_fresh_acc.ctrl = w_is_ctrl;
        w_fresh_acc.data = din;
    end

    // Accesses that need the VRAM FSM: any data-port access, and the second
    // control byte when it sets the address (it may start a prefetch and it
    // must not move the address under an outstanding request).
    assign w_fresh_fsm = w_is_data | (w_wr_start & w_is_ctrl & r_toggle & ~din[7]);
    assign w_busy      = (r_state != ST_IDLE);
    assign w_hold      = w_fresh & ((w_fresh_fsm & w_busy) | r_pend_vld);
    assign w_release   = r_pend_vld & ~w_busy;
    assign w_act       = w_release | (w_fresh & ~w_hold);
    assign w_acc       = w_release ? r_pend : w_fresh_acc;

    // Decode of the access acting this cycle (fresh or released from hold)
    assign w_do_latch = w_act &  w_acc.wr &  w_acc.ctrl & ~r_toggle;
    assign w_do_ctrl2 = w_act &  w_acc.wr &  w_acc.ctrl &  r_toggle;
    assign w_do_reg   = w_do_ctrl2 &  w_acc.data[7];
    assign w_do_addr  = w_do_ctrl2 & ~w_acc.data[7];
    assign w_do_vwr   = w_act &  w_acc.wr & ~w_acc.ctrl;
    assign w_do_drd   = w_act & ~w_acc.wr & ~w_acc.ctrl;
    assign w_do_srd   = w_act & ~w_acc.wr &  w_acc.ctrl;
    assign w_issue_wr = w_do_vwr;
    assign w_issue_rd = w_do_drd | (w_do_addr & ~w_acc.data[6]);

    // An ack seen while idle (e.g. after a reset mid-request) is stale.
    assign w_ack = vram_ack & w_busy;

    // ---------------------------------------------------------------
    // Held access slot and wait request
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_vld <= 1'b0;
            r_pend     <= '0;
        end else if (w_hold) begin
            r_pend_vld <= 1'b1;
            r_pend     <= w_fresh_acc;
        end else if (w_release) begin
            r_pend_vld <= 1'b0;
        end
    end

    assign wait_n = ~r_pend_vld;

    // ---------------------------------------------------------------
    // Control-port byte pairing, registers, address, read buffer
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_latch  <= 8'h00;
            r_toggle <= 1'b0;
            r_regs   <= '0;
        end else begin
            if (w_do_latch) begin
                r_latch  <= w_acc.data;
                r_toggle <= 1'b1;
            end else if (w_act) begin
                r_toggle <= 1'b0;
            end
            if (w_do_reg)
                r_regs[w_acc.data[2:0]] <= r_latch;
        end
    end

    // Address set and post-ack increment are exclusive: address setting is
    // only acted on while the FSM is idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= 14'd0;
            r_buf   <= 8'h00;
            r_wdata <= 8'h00;
            r_dout  <= 8'h00;
        end else begin
            if (w_do_addr)
                r_addr <= {w_acc.data[5:0], r_latch};
            else if (w_ack)
                r_addr <= r_addr + 14'd1;

            if (w_do_vwr)
                r_buf <= w_acc.data;
            else if (w_ack && r_state == ST_RD_REQ)
                r_buf <= vram_rdata;

            if (w_issue_wr)
                r_wdata <= w_acc.data;

            if (w_do_drd)
                r_dout <= r_buf;
            else if (w_do_srd)
                r_dout <= w_status;
        end
    end

    // ---------------------------------------------------------------
    // VRAM request FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue_wr)
                    w_state_nxt = ST_WR_REQ;
                else if (w_issue_rd)
                    w_state_nxt = ST_RD_REQ;
            end
            ST_WR_REQ, ST_RD_REQ: begin
                if (vram_ack)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        vram_req = (r_state != ST_IDLE);
        vram_we  = (r_state == ST_WR_REQ);
    end

    assign vram_addr  = r_addr;
    assign vram_wdata = r_wdata;
    assign dout       = r_dout;
    assign regs       = r_regs;

    vdp_status u_status (
        .clk       (clk),
        .reset_n   (reset_n),
        .frame_stb (frame_stb),
        .coll_stb  (coll_stb),
        .fifth_stb (fifth_stb),
        .fifth_num (fifth_num),
        .rd_clr    (w_do_srd),
        .irq_en    (r_regs[1][R1_IE]),
        .status    (w_status),
        .int_n     (int_n)
    );

endmodule

// File: tb/tb_vdp_cpu_if.sv
module tb_vdp_cpu_if;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic [7:0]  io_addr;
    logic        io_rd_n;
    logic        io_wr_n;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        wait_n;
    logic        int_n;
    logic        vram_req;
    logic        vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_ack = 1'b0;
    logic [7:0]  vram_rdata = 8'h00;
    logic [63:0] regs;
    logic        frame_stb;
    logic        coll_stb;
    logic        fifth_stb;
    logic [4:0]  fifth_num;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vdp_cpu_if dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en     (clk_en),
        .io_addr    (io_addr),
        .io_rd_n    (io_rd_n),
        .io_wr_n    (io_wr_n),
        .din        (din),
        .dout       (dout),
        .wait_n     (wait_n),
        .int_n      (int_n),
        .vram_req   (vram_req),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_ack   (vram_ack),
        .vram_rdata (vram_rdata),
        .regs       (regs),
        .frame_stb  (frame_stb),
        .coll_stb   (coll_stb),
        .fifth_stb  (fifth_stb),
        .fifth_num  (fifth_num)
    );

    // Video-block responder: acks each request after ack_dly cycles and logs it
    int          ack_dly   = 2;
    bit          auto_ack  = 1'b1;
    int          resp_cnt  = 0;
    int          req_cnt   = 0;
    int          stray_req = 0;
    int          stray_done = 0;
    bit          unstable  = 1'b0;
    logic [7:0]  rdata_val = 8'h00;
    logic [13:0] cap_addr, last_addr;
    logic        cap_we, last_we;
    logic [7:0]  cap_wdata, last_wdata;

    always @(negedge clk) begin
        if (vram_ack) begin
            vram_ack = 1'b0;
        end else if (stray_req != stray_done) begin
            vram_ack   = 1'b1;
            stray_done = stray_req;
        end else if (auto_ack && vram_req) begin
            if (resp_cnt == 0) begin
                cap_addr  = vram_addr;
                cap_we    = vram_we;
                cap_wdata = vram_wdata;
            end else if (vram_addr !== cap_addr || vram_we !== cap_we || vram_wdata !== cap_wdata) begin
                unstable = 1'b1;
            end
            resp_cnt++;
            if (resp_cnt >= ack_dly) begin
                vram_ack   = 1'b1;
                vram_rdata = rdata_val;
                last_addr  = cap_addr;
                last_we    = cap_we;
                last_wdata = cap_wdata;
                req_cnt++;
                resp_cnt   = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        io_addr = a;
        din     = d;
        io_wr_n = 1'b0;
        repeat (3) @(negedge clk);
        io_wr_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        io_addr = a;
        io_rd_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        d = dout;
        io_rd_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int  n;
        bit  expired;
        n = 0;
        expired = 1'b0;
        settle();
        while (vram_req !== 1'b0 || wait_n !== 1'b1) begin
            settle();
            n++;
            if (n > 60) begin
                expired = 1'b1;
                break;
            end
        end
        chk(tag, 64'(expired), 64'(0));
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_stb = 1'b1;
        @(negedge clk);
        frame_stb = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int         base;
        int         cyc;

        reset_n   = 1'b0;
        clk_en    = 1'b1;
        io_addr   = 8'h00;
        io_rd_n   = 1'b1;
        io_wr_n   = 1'b1;
        din       = 8'h00;
        frame_stb = 1'b0;
        coll_stb  = 1'b0;
        fifth_stb = 1'b0;
        fifth_num = 5'd0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_vram_req",  64'(vram_req),  64'(0));
        chk("rst_vram_we",   64'(vram_we),   64'(0));
        chk("rst_wait_n",    64'(wait_n),    64'(1));
        chk("rst_int_n",     64'(int_n),     64'(1));
        chk("rst_regs",      regs,           64'(0));
        chk("rst_vram_addr", 64'(vram_addr), 64'(0));
        chk("rst_dout",      64'(dout),      64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Address 0x0000 for write, then VRAM write 0xA5
        io_write(8'h99, 8'h00);
        io_write(8'h99, 8'h40);
        #1;
        chk("addrset_no_req", 64'(req_cnt), 64'(0));
        io_write(8'h98, 8'hA5);
        wait_idle("wr1_timeout");
        chk("wr1_count", 64'(req_cnt),    64'(1));
        chk("wr1_we",    64'(last_we),    64'(1));
        chk("wr1_addr",  64'(last_addr),  64'(14'h0000));
        chk("wr1_wdata", 64'(last_wdata), 64'(8'hA5));
        chk("wr1_incr",  64'(vram_addr),  64'(14'h0001));

        // Register write R7 = 0xF1
        base = req_cnt;
        io_write(8'h99, 8'hF1);
        io_write(8'h99, 8'h87);
        #1;
        chk("r7_value",  64'(regs[63:56]), 64'(8'hF1));
        chk("r7_no_req", 64'(req_cnt),     64'(base));

        // Read setup at 0x1234 with prefetch, then data-port reads
        rdata_val = 8'h5A;
        io_write(8'h99, 8'h34);
        io_write(8'h99, 8'h12);
        wait_idle("pf1_timeout");
        chk("pf1_addr", 64'(last_addr), 64'(14'h1234));
        chk("pf1_we",   64'(last_we),   64'(0));
        chk("pf1_incr", 64'(vram_addr), 64'(14'h1235));
        rdata_val = 8'h3C;
        io_read(8'h98, d);
        chk("rd98_first", 64'(d), 64'(8'h5A));
        wait_idle("pf2_timeout");
        chk("pf2_addr", 64'(last_addr), 64'(14'h1235));
        chk("pf2_incr", 64'(vram_addr), 64'(14'h1236));
        io_read(8'h98, d);
        chk("rd98_second", 64'(d), 64'(8'h3C));
        wait_idle("pf3_timeout");

        // Address wrap 0x3FFF -> 0x0000
        io_write(8'h99, 8'hFF);
        io_write(8'h99, 8'h7F);
        #1;
        chk("wrap_set", 64'(vram_addr), 64'(14'h3FFF));
        io_write(8'h98, 8'h11);
        wait_idle("wrap_timeout");
        chk("wrap_addr", 64'(last_addr), 64'(14'h3FFF));
        chk("wrap_next", 64'(vram_addr), 64'(14'h0000));

        // Frame interrupt and status read
        io_write(8'h99, 8'h20);
        io_write(8'h99, 8'h81);
        #1;
        chk("r1_value", 64'(regs[15:8]), 64'(8'h20));
        pulse_frame();
        repeat (2) @(negedge clk);
        #1;
        chk("int_asserted", 64'(int_n), 64'(0));
        io_read(8'h99, d);
        chk("status_f", 64'(d), 64'(8'h80));
        settle();
        chk("int_cleared", 64'(int_n), 64'(1));

        // frame_stb on the same cycle the status read starts: F must survive
        pulse_frame();
        repeat (2) @(negedge clk);
        @(negedge clk);
        io_addr   = 8'h99;
        io_rd_n   = 1'b0;
        frame_stb = 1'b1;
        @(negedge clk);
        frame_stb = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        d = dout;
        io_rd_n = 1'b1;
        chk("status_race_read", 64'(d), 64'(8'h80));
        repeat (2) @(negedge clk);
        #1;
        chk("int_set_wins", 64'(int_n), 64'(0));
        io_read(8'h99, d);
        chk("f_kept", 64'(d), 64'(8'h80));
        io_read(8'h99, d);
        chk("f_cleared", 64'(d), 64'(8'h00));

        // Collision and fifth sprite; second fifth event must not overwrite num
        @(negedge clk);
        coll_stb  = 1'b1;
        fifth_stb = 1'b1;
        fifth_num = 5'h13;
        @(negedge clk);
        coll_stb  = 1'b0;
        fifth_num = 5'h05;
        @(negedge clk);
        fifth_stb = 1'b0;
        fifth_num = 5'h00;
        io_read(8'h99, d);
        chk("status_c_5s", 64'(d), 64'(8'h73));
        io_read(8'h99, d);
        chk("status_cleared_num_kept", 64'(d), 64'(8'h13));

        // Slow ack: second data write is held with wait_n low
        ack_dly = 10;
        base = req_cnt;
        io_write(8'h98, 8'h01);
        @(negedge clk);
        io_addr = 8'h98;
        din     = 8'h02;
        io_wr_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("wait_asserted", 64'(wait_n), 64'(0));
        cyc = 0;
        while (wait_n === 1'b0 && cyc < 60) begin
            settle();
            cyc++;
        end
        chk("wait_released",     64'(wait_n),  64'(1));
        chk("first_done_first",  64'(req_cnt), 64'(base + 1));
        chk("second_started",    64'(vram_req), 64'(1));
        io_wr_n = 1'b1;
        wait_idle("held_timeout");
        chk("held_count", 64'(req_cnt),    64'(base + 2));
        chk("held_wdata", 64'(last_wdata), 64'(8'h02));
        chk("held_addr",  64'(last_addr),  64'(14'h0001));
        chk("req_stable", 64'(unstable),   64'(0));
        ack_dly = 2;

        // Reset in the middle of a request; stray ack afterwards is ignored
        auto_ack = 1'b0;
        io_write(8'h98, 8'h77);
        #1;
        chk("pre_reset_req", 64'(vram_req), 64'(1));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("reset_drops_req", 64'(vram_req), 64'(0));
        chk("reset_regs",      regs,          64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        stray_req++;
        repeat (3) @(negedge clk);
        #1;
        chk("stray_ack_addr", 64'(vram_addr), 64'(0));
        chk("stray_ack_req",  64'(vram_req),  64'(0));
        auto_ack = 1'b1;

        // Strobes without clk_en and other port numbers are ignored
        base = req_cnt;
        clk_en = 1'b0;
        io_write(8'h99, 8'h80);
        clk_en = 1'b1;
        io_write(8'h9A, 8'h44);
        io_write(8'h99, 8'h66);
        io_write(8'h99, 8'h83);
        #1;
        chk("ignored_r3",     64'(regs[31:24]), 64'(8'h66));
        chk("ignored_no_req", 64'(req_cnt),     64'(base));
        chk("ignored_addr",   64'(vram_addr),   64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vdp_cpu_if.md
VDP_CPU_IF -- requirements
Module: vdp_cpu_if

Interface
REQ-001 SHALL have port clk, input, 1: system clock (cpuClock domain).
REQ-002 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port clk_en, input, 1: CPU clock-enable strobe; qualifies all bus sampling.
REQ-004 SHALL have port io_addr, input, 8: CPU I/O address (A7:A0).
REQ-005 SHALL have port io_rd_n, input, 1: I/O read, active-low (RD|IORQ).
REQ-006 SHALL have port io_wr_n, input, 1: I/O write, active-low (WR|IORQ).
REQ-007 SHALL have port din, input, 8: CPU write data.
REQ-008 SHALL have port dout, output, 8: CPU read data; status on 0x99, read buffer otherwise.
REQ-009 SHALL have port wait_n, output, 1: CPU wait request, active-low.
REQ-010 SHALL have port int_n, output, 1: VDP interrupt, active-low.
REQ-011 SHALL have port vram_req, output, 1: VRAM access request to video block.
REQ-012 SHALL have port vram_we, output, 1: 1=write, 0=read; valid while vram_req=1.
REQ-013 SHALL have port vram_addr, output, 14: VRAM address.
REQ-014 SHALL have port vram_wdata, output, 8: VRAM write data.
REQ-015 SHALL have port vram_ack, input, 1: one-cycle completion from video block.
REQ-016 SHALL have port vram_rdata, input, 8: read data, valid with vram_ack.
REQ-017 SHALL have port regs, output, 64: R7..R0 packed {R7,...,R0}.
REQ-018 SHALL have port frame_stb, input, 1: end-of-active-frame pulse.
REQ-019 SHALL have port coll_stb, input, 1: sprite-collision pulse.
REQ-020 SHALL have port fifth_stb, input, 1: fifth-sprite pulse.
REQ-021 SHALL have port fifth_num, input, 5: sprite number qualifying fifth_stb.

Function
REQ-022 An access SHALL start on the clk_en cycle where io_rd_n or io_wr_n is sampled low after being sampled high; each access acts once.
REQ-023 Port 0x99 write, toggle=0: latch <= din; toggle <= 1.
REQ-024 Port 0x99 write, toggle=1: toggle <= 0; din[7]=1 -> R[din[2:0]] <= latch, din[6:3] ignored; din[7]=0 -> addr <= {din[5:0],latch}; din[6]=0 additionally starts a prefetch read.
REQ-025 Port 0x98 write: issue VRAM write of din at addr; read buffer <= din; toggle <= 0.
REQ-026 Port 0x98 read: dout = read buffer at access start; then issue prefetch read; toggle <= 0.
REQ-027 Port 0x99 read: dout = status {F,5S,C,num[4:0]}; after access, F, 5S, C <= 0; toggle <= 0.
REQ-028 FSM states IDLE, WR_REQ, RD_REQ; IDLE->WR_REQ/RD_REQ on issue; back to IDLE on the vram_ack cycle.
REQ-029 vram_req SHALL be 1 throughout WR_REQ/RD_REQ; vram_addr/vram_wdata/vram_we SHALL be stable until ack.
REQ-030 On ack: addr <= addr+1, mod 2^14 (0x3FFF -> 0x0000); in RD_REQ, buffer <= vram_rdata.
REQ-031 Data-port access or address-setting 0x99 write starting while FSM not IDLE SHALL drive wait_n=0 and hold the access until IDLE, then act on it.
REQ-032 frame_stb sets F; coll_stb sets C; fifth_stb sets 5S and num <= fifth_num, but only when 5S=0.
REQ-033 Same-cycle set and read-clear: set SHALL win.
REQ-034 int_n SHALL be !(F & R1[5]), registered, one cycle latency.
REQ-035 Register writes and 0x98/0x99 decoding SHALL ignore all other io_addr values.

Reset
REQ-036 On reset_n=0, asynchronously: R0..R7=0, addr=0, latch=0, toggle=0, buffer=0, status=0, FSM=IDLE, vram_req=0, vram_we=0, wait_n=1, int_n=1.
REQ-037 Reset mid-request SHALL drop vram_req immediately; a later vram_ack in IDLE SHALL be ignored.

Structure
REQ-038 Shared package msx_pkg SHALL hold port constants 0x98/0x99, FSM state enum, status bit indices.
REQ-039 Status register plus int_n logic SHALL be sub-module vdp_status.

Verification
REQ-040 Write 0x99 0x00, 0x99 0x40, 0x98 0xA5 -> one vram_req, vram_we=1, addr 0x0000, wdata 0xA5; addr 0x0001 after ack.
REQ-041 Write 0x99 0xF1, 0x99 0x87 -> R7=0xF1, no VRAM request.
REQ-042 Write 0x99 0x34, 0x99 0x12 with ack data 0x5A -> read at 0x1234, buffer 0x5A; read 0x98 -> 0x5A, then read at 0x1235.
REQ-043 Address 0x3FFF, write 0x98 -> next address 0x0000.
REQ-044 R1=0x20, pulse frame_stb -> int_n=0; read 0x99 -> 0x80; int_n=1 next cycle; frame_stb same cycle as read -> F stays 1.
REQ-045 Hold vram_ack low 10 cycles, issue second 0x98 write -> wait_n=0 until ack, second write starts after.
